// File: rtl/pz_pkg.sv
// Shared FSM type, header field layout and slot width for the pole/zero loader.
package pz_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_DRAIN  = 2'd3
   } pz_state_e;

   localparam int NZ_MSB = 15;
   localparam int NZ_LSB = 8;
   localparam int NP_MSB = 7;
   localparam int NP_LSB = 0;
   localparam int NZ_W   = NZ_MSB - NZ_LSB + 1;
   localparam int NP_W   = NP_MSB - NP_LSB + 1;
   localparam int PZ_W   = 16;

   // One spare bit so nz+np (plus an optional checksum word) never wraps.
   localparam int CNT_W  = NZ_W + 1;

   function automatic logic [CNT_W-1:0] hdr_slots(input logic [PZ_W-1:0] hdr);
      return CNT_W'(hdr[NZ_MSB:NZ_LSB]) + CNT_W'(hdr[NP_MSB:NP_LSB]);
   endfunction

endpackage

// File: rtl/pz_shadow_bank.sv
// Shadow slots filled during a frame and active slots that only change on commit.
module pz_shadow_bank
   import pz_pkg::*;
#(
   parameter int REG_FILE_SIZE = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr_i,
   input  logic                          wr_en_i,
   input  logic [CNT_W-1:0]              wr_idx_i,
   input  logic [PZ_W-1:0]               wr_data_i,
   input  logic                          commit_i,
   output logic [PZ_W*REG_FILE_SIZE-1:0] flat_pz_o
);

   logic [PZ_W-1:0]               shadow_q [REG_FILE_SIZE];
   logic [PZ_W*REG_FILE_SIZE-1:0] shadow_flat;
   logic [PZ_W*REG_FILE_SIZE-1:0] active_q;

   always_comb begin
      shadow_flat = '0;
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
         shadow_flat[PZ_W*i +: PZ_W] = shadow_q[i];
      end
   end

   // NOTE: this small slot array is reset on purpose -- it must read as zero after rst, so it stays flops rather than RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_FILE_SIZE; i++) begin
            shadow_q[i] <= '0;
         end
         active_q <= '0;
      end else begin
         for (int i = 0; i < REG_FILE_SIZE; i++) begin
            if (clr_i) begin
               shadow_q[i] <= '0;
            end else if (wr_en_i && (wr_idx_i == CNT_W'(i))) begin
               shadow_q[i] <= wr_data_i;
            end
         end
         if (commit_i) begin
            active_q <= shadow_flat;
         end
      end
   end

   assign flat_pz_o = active_q;

endmodule

// File: rtl/pz_regfile_loader.sv
// Parses header/zeros/poles frames into a shadow bank and commits them atomically.
// Define PZ_LOADER_CHECKSUM_EN to require a trailing 16-bit wrap-around checksum word.
module pz_regfile_loader
   import pz_pkg::*;
#(
   parameter int REG_FILE_SIZE = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [15:0]                   s_data,
   input  logic                          s_last,
   output logic [16*REG_FILE_SIZE-1:0]   flat_pz,
   output logic [31:0]                   no_z,
   output logic [31:0]                   no_p,
   output logic                          load_done,
   output logic                          load_err,
   output logic                          busy
);

   localparam logic [CNT_W-1:0] SLOTS = CNT_W'(REG_FILE_SIZE);

   pz_state_e        state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [NZ_W-1:0]  nz_q, nz_d, no_z_q;
   logic [NP_W-1:0]  np_q, np_d, no_p_q;
   logic             err_q, err_d, done_q;
   logic             accept, last_word;
   logic             bank_clr, bank_wr, bank_commit;
   logic [CNT_W-1:0] hdr_vals, vals_q, total_q;
`ifdef PZ_LOADER_CHECKSUM_EN
   logic [PZ_W-1:0]  sum_q, sum_d;
`endif

   assign accept   = s_valid && s_ready;
   assign hdr_vals = hdr_slots(s_data);
   assign vals_q   = CNT_W'(nz_q) + CNT_W'(np_q);
`ifdef PZ_LOADER_CHECKSUM_EN
   assign total_q  = vals_q + CNT_W'(1);
`else
   assign total_q  = vals_q;
`endif
   assign last_word = (idx_q + CNT_W'(1)) == total_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      nz_d    = nz_q;
      np_d    = np_q;
      err_d   = err_q;
`ifdef PZ_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         ST_IDLE: if (accept) begin
            nz_d  = s_data[NZ_MSB:NZ_LSB];
            np_d  = s_data[NP_MSB:NP_LSB];
            idx_d = '0;
            err_d = 1'b0;
`ifdef PZ_LOADER_CHECKSUM_EN
            sum_d = s_data;
`endif
            if (hdr_vals > SLOTS) begin
               err_d   = 1'b1;
               state_d = s_last ? ST_IDLE : ST_DRAIN;
`ifdef PZ_LOADER_CHECKSUM_EN
            end else if (s_last) begin
               // A header can never also be the checksum word.
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOAD;
            end
`else
            end else if (hdr_vals == '0) begin
               if (s_last) begin
                  state_d = ST_COMMIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_DRAIN;
               end
            end else begin
               state_d = ST_LOAD;
            end
`endif
         end
         ST_LOAD: if (accept) begin
            idx_d = idx_q + CNT_W'(1);
`ifdef PZ_LOADER_CHECKSUM_EN
            sum_d = sum_q + s_data;
`endif
            if (s_last && !last_word) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (last_word && !s_last) begin
               err_d   = 1'b1;
               state_d = ST_DRAIN;
            end else if (last_word) begin
`ifdef PZ_LOADER_CHECKSUM_EN
               if (s_data != sum_q) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_COMMIT;
               end
`else
               state_d = ST_COMMIT;
`endif
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         ST_DRAIN:  if (accept && s_last) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // s_ready is 1 in IDLE and LOAD, so s_valid alone qualifies the bank strobes there.
   always_comb begin
      s_ready     = (state_q != ST_COMMIT);
      busy        = (state_q != ST_IDLE);
      bank_clr    = (state_q == ST_IDLE) && s_valid;
      bank_wr     = (state_q == ST_LOAD) && s_valid && (idx_q < vals_q);
      bank_commit = (state_q == ST_COMMIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         nz_q   <= '0;
         np_q   <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
         no_z_q <= '0;
         no_p_q <= '0;
`ifdef PZ_LOADER_CHECKSUM_EN
         sum_q  <= '0;
`endif
      end else begin
         idx_q  <= idx_d;
         nz_q   <= nz_d;
         np_q   <= np_d;
         err_q  <= err_d;
         done_q <= (state_q == ST_COMMIT);
`ifdef PZ_LOADER_CHECKSUM_EN
         sum_q  <= sum_d;
`endif
         if (state_q == ST_COMMIT) begin
            no_z_q <= nz_q;
            no_p_q <= np_q;
         end
      end
   end

   pz_shadow_bank #(
      .REG_FILE_SIZE (REG_FILE_SIZE)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (bank_clr),
      .wr_en_i   (bank_wr),
      .wr_idx_i  (idx_q),
      .wr_data_i (s_data),
      .commit_i  (bank_commit),
      .flat_pz_o (flat_pz)
   );

   assign no_z      = 32'(no_z_q);
   assign no_p      = 32'(no_p_q);
   assign load_done = done_q;
   assign load_err  = err_q;

endmodule

// File: tb/tb_pz_regfile_loader.sv
// Self-checking bench: frame-level model compared every cycle, plus literal spot checks.
module tb_pz_regfile_loader;

   localparam int N = 2;

   logic          clk = 1'b0;
   logic          rst, s_valid, s_ready, s_last, load_done, load_err, busy;
   logic [15:0]   s_data;
   logic [16*N-1:0] flat_pz;
   logic [31:0]   no_z, no_p;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   pz_regfile_loader #(.REG_FILE_SIZE(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .flat_pz   (flat_pz),
      .no_z      (no_z),
      .no_p      (no_p),
      .load_done (load_done),
      .load_err  (load_err),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: words of the current frame are queued and judged against the frame rules.
   logic [15:0] m_slot [N];
   logic [15:0] m_pend [N];
   int          m_nz, m_np, p_nz, p_np, f_nz, f_np;
   bit          m_err, m_done, m_in_frame, m_drain, m_commit;
   logic [15:0] frm [$];
   logic [16*N-1:0] exp_flat;

   function automatic logic [15:0] frame_sum();
      logic [15:0] s = 16'h0;
      for (int i = 0; i < frm.size() - 1; i++) s += frm[i];
      return s;
   endfunction

   task automatic schedule_commit();
      for (int i = 0; i < N; i++) m_pend[i] = (i < f_nz + f_np) ? frm[i+1] : 16'h0;
      p_nz = f_nz;
      p_np = f_np;
      m_commit = 1'b1;
   endtask

   task automatic model_word(input logic [15:0] w, input bit last);
      int need, got;
      if (m_drain) begin
         if (last) m_drain = 1'b0;
      end else if (!m_in_frame) begin
         frm.delete();
         frm.push_back(w);
         f_nz  = int'(w[15:8]);
         f_np  = int'(w[7:0]);
         m_err = 1'b0;
         if (f_nz + f_np > N) begin
            m_err   = 1'b1;
            m_drain = !last;
`ifdef PZ_LOADER_CHECKSUM_EN
         end else if (last) begin
            m_err = 1'b1;
         end else begin
            m_in_frame = 1'b1;
         end
`else
         end else if (f_nz + f_np == 0) begin
            if (last) schedule_commit();
            else begin
               m_err   = 1'b1;
               m_drain = 1'b1;
            end
         end else begin
            m_in_frame = 1'b1;
         end
`endif
      end else begin
         frm.push_back(w);
`ifdef PZ_LOADER_CHECKSUM_EN
         need = f_nz + f_np + 1;
`else
         need = f_nz + f_np;
`endif
         got = frm.size() - 1;
         if (last && got < need) begin
            m_err = 1'b1;
            m_in_frame = 1'b0;
         end else if (got == need && !last) begin
            m_err = 1'b1;
            m_drain = 1'b1;
            m_in_frame = 1'b0;
         end else if (got == need) begin
            m_in_frame = 1'b0;
`ifdef PZ_LOADER_CHECKSUM_EN
            if (frame_sum() != w) m_err = 1'b1;
            else schedule_commit();
`else
            schedule_commit();
`endif
         end
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) m_slot[i] = 16'h0;
         m_nz = 0; m_np = 0;
         m_err = 1'b0; m_done = 1'b0; m_in_frame = 1'b0; m_drain = 1'b0; m_commit = 1'b0;
         frm.delete();
      end else begin
         m_done = 1'b0;
         if (m_commit) begin
            m_slot   = m_pend;
            m_nz     = p_nz;
            m_np     = p_np;
            m_done   = 1'b1;
            m_commit = 1'b0;
         end else if (s_valid) begin
            model_word(s_data, s_last);
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < N; i++) exp_flat[16*i +: 16] = m_slot[i];
         check("flat_pz",   flat_pz,   exp_flat);
         check("no_z",      no_z,      64'(m_nz));
         check("no_p",      no_p,      64'(m_np));
         check("load_done", load_done, m_done ? 64'd1 : 64'd0);
         check("load_err",  load_err,  m_err ? 64'd1 : 64'd0);
         check("s_ready",   s_ready,   m_commit ? 64'd0 : 64'd1);
         check("busy",      busy,      (m_in_frame || m_drain || m_commit) ? 64'd1 : 64'd0);
      end
   end

   // Drives one word, holding it until the handshake edge; returns 1 time unit after that edge.
   task automatic send_word(input logic [15:0] w, input logic last, input int gap);
      bit done;
      for (int g = 0; g < gap; g++) begin
         s_valid = 1'b0;
         @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = w;
      s_last  = last;
      done    = 1'b0;
      for (int t = 0; t < 16 && !done; t++) begin
         @(negedge clk);
         done = s_ready;
         @(posedge clk); #1;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL handshake: word %0h not accepted within 16 cycles", w);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   logic [15:0] fq [$];

   task automatic send_frame(input bit gaps);
      int n;
`ifdef PZ_LOADER_CHECKSUM_EN
      logic [15:0] sum;
      sum = 16'h0;
`endif
      n = fq.size();
      for (int i = 0; i < n; i++) begin
`ifdef PZ_LOADER_CHECKSUM_EN
         sum += fq[i];
         send_word(fq[i], 1'b0, gaps ? int'($urandom_range(1, 3)) : 0);
`else
         send_word(fq[i], (i == n - 1), gaps ? int'($urandom_range(1, 3)) : 0);
`endif
      end
`ifdef PZ_LOADER_CHECKSUM_EN
      send_word(sum, 1'b1, gaps ? int'($urandom_range(1, 3)) : 0);
`endif
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0;
      @(posedge clk); #1;
      cmp_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst flat_pz", flat_pz, 64'h0);
      check("rst busy", busy, 64'd0);
      check("rst s_ready", s_ready, 64'd1);

      // Basic one-zero one-pole frame: outputs update two edges after the final word.
      fq.delete(); fq.push_back(16'h0101); fq.push_back(16'h0064); fq.push_back(16'hFF9C);
      send_frame(1'b0);
      check("commit-cycle s_ready", s_ready, 64'd0);
      check("commit-cycle flat_pz", flat_pz, 64'h0);
      @(posedge clk); #1;
      check("basic flat_pz", flat_pz, 64'hFF9C_0064);
      check("basic no_z", no_z, 64'd1);
      check("basic no_p", no_p, 64'd1);
      check("basic load_done", load_done, 64'd1);
      check("basic load_err", load_err, 64'd0);
      @(posedge clk); #1;
      check("basic load_done pulse", load_done, 64'd0);

      // Oversized header drains until last.
      send_word(16'h0201, 1'b0, 0);
      check("oversize err", load_err, 64'd1);
      check("oversize busy", busy, 64'd1);
      send_word(16'h0001, 1'b0, 0);
      send_word(16'h0002, 1'b0, 0);
      send_word(16'h0003, 1'b1, 0);
      check("oversize idle", busy, 64'd0);
      check("oversize flat_pz", flat_pz, 64'hFF9C_0064);

      // Early last.
      send_word(16'h0002, 1'b0, 0);
      send_word(16'h0010, 1'b1, 0);
      check("early err", load_err, 64'd1);
      check("early busy", busy, 64'd0);
      check("early no_p", no_p, 64'd1);
      fq.delete(); fq.push_back(16'h0200); fq.push_back(16'h1111); fq.push_back(16'h2222);
      send_frame(1'b0);
      @(posedge clk); #1;
      check("after-early flat_pz", flat_pz, 64'h2222_1111);
      check("after-early no_z", no_z, 64'd2);
      check("after-early err", load_err, 64'd0);

      // Late last, then oversize header carrying last.
      send_word(16'h0001, 1'b0, 0);
      send_word(16'h5555, 1'b0, 0);
      send_word(16'h7777, 1'b1, 0);
      check("late err", load_err, 64'd1);
      check("late flat_pz", flat_pz, 64'h2222_1111);
      send_word(16'h0300, 1'b1, 0);
      check("oversize-last busy", busy, 64'd0);

      // Empty frame after a prior commit.
      fq.delete(); fq.push_back(16'h0000);
      send_frame(1'b0);
      @(posedge clk); #1;
      check("empty flat_pz", flat_pz, 64'h0);
      check("empty no_z", no_z, 64'd0);
      check("empty load_done", load_done, 64'd1);

      // Same basic frame with valid gaps.
      fq.delete(); fq.push_back(16'h0101); fq.push_back(16'h0064); fq.push_back(16'hFF9C);
      send_frame(1'b1);
      @(posedge clk); #1;
      check("gaps flat_pz", flat_pz, 64'hFF9C_0064);
      check("gaps load_done", load_done, 64'd1);

      // Reset after header; the next word must be parsed as a header.
      send_word(16'h0101, 1'b0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst flat_pz", flat_pz, 64'h0);
      check("midrst no_p", no_p, 64'd0);
      check("midrst busy", busy, 64'd0);
      fq.delete(); fq.push_back(16'h0001); fq.push_back(16'hABCD);
      send_frame(1'b0);
      @(posedge clk); #1;
      check("postrst flat_pz", flat_pz, 64'h0000_ABCD);
      check("postrst no_p", no_p, 64'd1);

`ifdef PZ_LOADER_CHECKSUM_EN
      send_word(16'h0101, 1'b0, 0);
      send_word(16'h0064, 1'b0, 0);
      send_word(16'hFF9C, 1'b0, 0);
      send_word(16'h0102, 1'b1, 0);
      @(posedge clk); #1;
      check("badsum err", load_err, 64'd1);
      check("badsum flat_pz", flat_pz, 64'h0000_ABCD);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
